// File: rtl/mdu_unit_if.sv
// Request/response bundle between an issuing pipeline and the multiply/divide unit.
// The master drives the operation request; the slave reports busy/done and the HI/LO registers.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             cancel_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, cancel_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, cancel_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers (MIPS-style MULT/DIV/MTHI/MTLO).
// Result is computed from the operands captured at launch and committed when the busy counter expires.
module mdu_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_unit_if.slave  bus
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    // ---------------- result datapath (operates on captured request) ----------------
    logic               is_signed;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic               neg_a, neg_b, div_zero;
    logic [WIDTH-1:0]   mag_a, mag_b, divisor, quo, rem, quo_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign is_signed = req_q.op[0];

    // Sign-extending to 2*WIDTH makes the low half of a plain product the signed product.
    assign mul_a = {{WIDTH{is_signed & req_q.a[WIDTH-1]}}, req_q.a};
    assign mul_b = {{WIDTH{is_signed & req_q.b[WIDTH-1]}}, req_q.b};
    assign prod  = mul_a * mul_b;

    // Signed divide via magnitudes; MIN / -1 wraps back to MIN with remainder 0 naturally.
    assign neg_a    = is_signed & req_q.a[WIDTH-1];
    assign neg_b    = is_signed & req_q.b[WIDTH-1];
    assign mag_a    = neg_a ? -req_q.a : req_q.a;
    assign mag_b    = neg_b ? -req_q.b : req_q.b;
    assign div_zero = (req_q.b == '0);
    assign divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    assign quo      = mag_a / divisor;
    assign rem      = mag_a % divisor;
    assign quo_s    = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_s    = neg_a ? -rem : rem;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!req_q.op[1]) begin
            {res_hi, res_lo} = prod;
        end else if (div_zero) begin
            res_hi = req_q.a;
            res_lo = '1;
        end else begin
            res_hi = rem_s;
            res_lo = quo_s;
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // cancel is meaningless here; a coincident start still launches
                if (bus.start_i) begin
                    unique case (bus.op_i)
                        OP_MULTU, OP_MULT: begin
                            req_d   = '{op: bus.op_i, a: bus.data1_i, b: bus.data2_i};
                            cnt_d   = MUL_LOAD;
                            state_d = RUN;
                        end
                        OP_DIVU, OP_DIV: begin
                            req_d   = '{op: bus.op_i, a: bus.data1_i, b: bus.data2_i};
                            cnt_d   = DIV_LOAD;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = bus.data1_i;
                        OP_MTLO: lo_d = bus.data1_i;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o = (state_q == RUN);
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: a 32-bit default instance and an 8-bit single-cycle-multiply instance.
// Expected HI/LO come from an arithmetic reference model; monitors pop and compare on every done pulse.
module tb_mdu_unit;
    logic clk;
    logic rst_n;

    mdu_unit_if #(.WIDTH(32)) bus_a ();
    mdu_unit_if #(.WIDTH(8))  bus_b ();

    mdu_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    mdu_unit #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] qa[$];
    logic [15:0] qb[$];
    logic [31:0] mhi_a, mlo_a;
    logic [7:0]  mhi_b, mlo_b;
    logic [63:0] e_a;
    logic [15:0] e_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic on sign/zero-extended operands.
    function automatic logic [127:0] model(input int w, input logic [2:0] op,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] hi, input logic [63:0] lo);
        longint unsigned mask, ua, ub, up, nhi, nlo;
        longint          sa, sb, sp;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = $signed(ua << (64 - w)) >>> (64 - w);
        sb   = $signed(ub << (64 - w)) >>> (64 - w);
        nhi  = hi;
        nlo  = lo;
        case (op)
            3'd0: begin up = ua * ub; nhi = (up >> w) & mask; nlo = up & mask; end
            3'd1: begin sp = sa * sb; up = $unsigned(sp); nhi = (up >> w) & mask; nlo = up & mask; end
            3'd2: begin
                if (ub == 0) begin nhi = ua; nlo = mask; end
                else begin nlo = ua / ub; nhi = ua % ub; end
            end
            3'd3: begin
                if (sb == 0) begin nhi = ua; nlo = mask; end
                else begin
                    sp = sa / sb; nlo = $unsigned(sp) & mask;
                    sp = sa % sb; nhi = $unsigned(sp) & mask;
                end
            end
            3'd4: nhi = ua;
            3'd5: nlo = ua;
            default: ;
        endcase
        return {nhi, nlo};
    endfunction

    function automatic logic [63:0] rnd(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return 64'd1;
            4: return 64'($urandom_range(0, 20));
            default: return {32'd0, $urandom} & mask;
        endcase
    endfunction

    // Launch on A from a negedge with busy low; returns at a negedge with busy low.
    // While busy, start is held high with junk (first cycle: MTHI 0x1234) to show it is ignored.
    task automatic do_op_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int cancel_at, input bit directed, input logic [63:0] exp_hl);
        int n, cyc;
        logic [127:0] r;
        n = op[1] ? 10 : 5;
        r = model(32, op, {32'd0, a}, {32'd0, b}, {32'd0, mhi_a}, {32'd0, mlo_a});
        if (directed) r = {32'd0, exp_hl[63:32], 32'd0, exp_hl[31:0]};
        bus_a.start_i = 1'b1; bus_a.op_i = op; bus_a.data1_i = a; bus_a.data2_i = b;
        bus_a.cancel_i = 1'b0;
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        if (op <= 3'd3) begin
            if (cancel_at == 0) begin
                qa.push_back({r[95:64], r[31:0]});
                mhi_a = r[95:64]; mlo_a = r[31:0];
            end
            cyc = 0;
            @(negedge clk);
            while (bus_a.busy_o === 1'b1 && cyc < 100) begin
                cyc++;
                bus_a.cancel_i = (cyc == cancel_at);
                bus_a.start_i  = 1'b1;
                bus_a.op_i     = (cyc == 1) ? 3'd4 : 3'($urandom_range(0, 7));
                bus_a.data1_i  = (cyc == 1) ? 32'h1234 : $urandom;
                bus_a.data2_i  = $urandom;
                @(negedge clk);
            end
            bus_a.start_i = 1'b0; bus_a.cancel_i = 1'b0;
            chk("busy_len_a", 64'(cyc), 64'((cancel_at != 0) ? cancel_at : n));
            if (cancel_at != 0) begin
                chk("cancel_hi_a", {32'd0, bus_a.hi_o}, {32'd0, mhi_a});
                chk("cancel_lo_a", {32'd0, bus_a.lo_o}, {32'd0, mlo_a});
            end
        end else begin
            mhi_a = r[95:64]; mlo_a = r[31:0];
            @(negedge clk);
            chk("idle_busy_a", {63'd0, bus_a.busy_o}, 64'd0);
            chk("idle_hi_a", {32'd0, bus_a.hi_o}, {32'd0, mhi_a});
            chk("idle_lo_a", {32'd0, bus_a.lo_o}, {32'd0, mlo_a});
        end
    endtask

    task automatic do_op_b(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        logic [127:0] r;
        r = model(8, op, {56'd0, a}, {56'd0, b}, {56'd0, mhi_b}, {56'd0, mlo_b});
        bus_b.start_i = 1'b1; bus_b.op_i = op; bus_b.data1_i = a; bus_b.data2_i = b;
        @(posedge clk); #1;
        bus_b.start_i = 1'b0;
        mhi_b = r[71:64]; mlo_b = r[7:0];
        if (op <= 3'd3) begin
            qb.push_back({r[71:64], r[7:0]});
            cyc = 0;
            @(negedge clk);
            while (bus_b.busy_o === 1'b1 && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            chk("busy_len_b", 64'(cyc), op[1] ? 64'd3 : 64'd1);
        end else begin
            @(negedge clk);
            chk("idle_busy_b", {63'd0, bus_b.busy_o}, 64'd0);
            chk("idle_hi_b", {56'd0, bus_b.hi_o}, {56'd0, mhi_b});
            chk("idle_lo_b", {56'd0, bus_b.lo_o}, {56'd0, mlo_b});
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_a.done_o === 1'b1) begin
            if (qa.size() == 0) chk("spurious_done_a", 64'd1, 64'd0);
            else begin
                e_a = qa.pop_front();
                chk("hi_a", {32'd0, bus_a.hi_o}, {32'd0, e_a[63:32]});
                chk("lo_a", {32'd0, bus_a.lo_o}, {32'd0, e_a[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_b.done_o === 1'b1) begin
            if (qb.size() == 0) chk("spurious_done_b", 64'd1, 64'd0);
            else begin
                e_b = qb.pop_front();
                chk("hi_b", {56'd0, bus_b.hi_o}, {56'd0, e_b[15:8]});
                chk("lo_b", {56'd0, bus_b.lo_o}, {56'd0, e_b[7:0]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        int ca;
        rst_n = 1'b0;
        bus_a.start_i = 0; bus_a.op_i = 0; bus_a.data1_i = 0; bus_a.data2_i = 0; bus_a.cancel_i = 0;
        bus_b.start_i = 0; bus_b.op_i = 0; bus_b.data1_i = 0; bus_b.data2_i = 0; bus_b.cancel_i = 0;
        mhi_a = 0; mlo_a = 0; mhi_b = 0; mlo_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus_a.busy_o}, 64'd0);
        chk("rst_done", {63'd0, bus_a.done_o}, 64'd0);
        chk("rst_hi",   {32'd0, bus_a.hi_o}, 64'd0);
        chk("rst_lo",   {32'd0, bus_a.lo_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results
        do_op_a(3'd0, 32'hFFFF_FFFF, 32'd2,          0, 1, {32'h0000_0001, 32'hFFFF_FFFE});
        do_op_a(3'd1, 32'hFFFF_FFFD, 32'd7,          0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        do_op_a(3'd3, 32'hFFFF_FFF9, 32'd2,          0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op_a(3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  0, 1, {32'h0000_0000, 32'h8000_0000});
        do_op_a(3'd2, 32'd5,         32'd0,          0, 1, {32'h0000_0005, 32'hFFFF_FFFF});
        do_op_a(3'd4, 32'hCAFE,      32'd0,          0, 0, 64'd0);
        do_op_a(3'd5, 32'hBEEF,      32'd0,          0, 0, 64'd0);
        do_op_a(3'd2, 32'd100,       32'd7,          4, 0, 64'd0);
        do_op_a(3'd2, 32'd100,       32'd7,         10, 0, 64'd0);
        do_op_a(3'd6, 32'd1,         32'd2,          0, 0, 64'd0);

        // Reset in the middle of a multiply clears HI/LO without waiting for a clock
        bus_a.start_i = 1'b1; bus_a.op_i = 3'd1; bus_a.data1_i = 32'd5; bus_a.data2_i = 32'd9;
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, bus_a.busy_o}, 64'd0);
        chk("midrst_done", {63'd0, bus_a.done_o}, 64'd0);
        chk("midrst_hi",   {32'd0, bus_a.hi_o}, 64'd0);
        chk("midrst_lo",   {32'd0, bus_a.lo_o}, 64'd0);
        mhi_a = 0; mlo_a = 0; mhi_b = 0; mlo_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op_a(3'd0, 32'd6, 32'd7, 0, 1, {32'd0, 32'd42});

        // Randomized traffic with occasional cancels
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            ca = 0;
            if (op <= 3'd3 && $urandom_range(0, 5) == 0)
                ca = $urandom_range(1, op[1] ? 10 : 5);
            do_op_a(op, rnd(32), rnd(32), ca, 0, 64'd0);
        end

        // Narrow instance: single-cycle multiply
        bus_b.start_i = 1'b1; bus_b.op_i = 3'd0; bus_b.data1_i = 8'hFF; bus_b.data2_i = 8'hFF;
        qb.push_back(16'hFE01);
        @(posedge clk); #1;
        bus_b.start_i = 1'b0;
        @(negedge clk);
        chk("b_busy_1", {63'd0, bus_b.busy_o}, 64'd1);
        @(negedge clk);
        chk("b_busy_0", {63'd0, bus_b.busy_o}, 64'd0);
        mhi_b = 8'hFE; mlo_b = 8'h01;

        // start held high: a launch every second cycle
        bus_b.start_i = 1'b1; bus_b.op_i = 3'd0; bus_b.data1_i = 8'h0F; bus_b.data2_i = 8'h11;
        for (int i = 0; i < 5; i++) qb.push_back(16'h00FF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b_held_busy", {63'd0, bus_b.busy_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        bus_b.start_i = 1'b0;
        mhi_b = 8'h00; mlo_b = 8'hFF;
        @(negedge clk);

        for (int i = 0; i < 30; i++)
            do_op_b(3'($urandom_range(0, 7)), 8'(rnd(8)), 8'(rnd(8)));

        repeat (3) @(negedge clk);
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
